// File: rtl/sipo_frame_rx_ctrl_pkg.sv
// sipo_rx_pkg -- shared FSM encoding and counter sizing helpers for the serial frame receiver.
// Rev 1.0
`default_nettype none

package sipo_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   function automatic int mid_bit(input int div);
      return div / 2 - 1;
   endfunction

   function automatic int clk_cnt_w(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

   function automatic int bit_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_frame_rx_ctrl_shift_reg.sv
// sipo_shift_reg -- right-shifting SIPO; serial input enters the MSB.
// Rev 1.0
`default_nettype none

module sipo_shift_reg
   import sipo_rx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             SHIFT_EN,
   input  logic             SER_IN,
   output logic [WIDTH-1:0] PAR_OUT
);

   logic [WIDTH-1:0] sr_q;

   generate
      if (WIDTH == 1) begin : g_single
         always_ff @(posedge CLK) begin
            if (RESET)         sr_q <= '0;
            else if (SHIFT_EN) sr_q <= SER_IN;
         end
      end else begin : g_multi
         always_ff @(posedge CLK) begin
            if (RESET)         sr_q <= '0;
            else if (SHIFT_EN) sr_q <= {SER_IN, sr_q[WIDTH-1:1]};
         end
      end
   endgenerate

   assign PAR_OUT = sr_q;

endmodule

`default_nettype wire

// File: rtl/sipo_frame_rx_ctrl.sv
// sipo_frame_rx_ctrl -- oversampling serial frame receiver driving a SIPO, with VALID/READY output.
// Rev 1.0
`default_nettype none

module sipo_frame_rx_ctrl
   import sipo_rx_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             DATA_IN,
   input  logic             READY,
   output logic [WIDTH-1:0] Q,
   output logic             VALID,
   output logic             BUSY,
   output logic             FRAME_ERR,
   output logic             OVERRUN
);

   localparam int CW = clk_cnt_w(DIV);
   localparam int BW = bit_cnt_w(WIDTH);
   localparam logic [CW-1:0] MID      = CW'(mid_bit(DIV));
   localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             sync1_q, sync2_q, prev_q;
   logic [WIDTH-1:0] q_q;
   logic             valid_q, ferr_q, ovr_q;
   logic [WIDTH-1:0] sipo;
   logic             shift_en, stop_sample, load, ovr_d, ferr_d;

   sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
      .CLK      (CLK),
      .RESET    (RESET),
      .SHIFT_EN (shift_en),
      .SER_IN   (sync2_q),
      .PAR_OUT  (sipo)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CW'(1);
      bit_d       = bit_q;
      shift_en    = 1'b0;
      stop_sample = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (prev_q && !sync2_q) state_d = START;
         end
         START: begin
            if (cnt_q == MID) begin
               cnt_d = '0;
               bit_d = '0;
               // A line back high at mid-start is treated as a glitch.
               state_d = sync2_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d    = '0;
               shift_en = 1'b1;
               if (bit_q == LAST_BIT) state_d = STOP;
               else                   bit_d   = bit_q + BW'(1);
            end
         end
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d       = '0;
               stop_sample = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign load   = stop_sample && sync2_q && (!valid_q || READY);
   assign ovr_d  = stop_sample && sync2_q && valid_q && !READY;
   assign ferr_d = stop_sample && !sync2_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         q_q     <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sync1_q <= DATA_IN;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         // A load on a transfer edge keeps VALID high with the new word.
         if (load) begin
            q_q     <= sipo;
            valid_q <= 1'b1;
         end else if (valid_q && READY) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign Q         = q_q;
   assign VALID     = valid_q;
   assign BUSY      = (state_q != IDLE);
   assign FRAME_ERR = ferr_q;
   assign OVERRUN   = ovr_q;

endmodule

`default_nettype wire
